// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus: stall requests and commit events in, per-stage
// hold/flush controls, fetch redirect and statistics out.
interface pipe_ctrl_if;
  logic        icache_stall_i;
  logic        id_stallreq_i;
  logic        ex_stallreq_i;
  logic        dcache_stall_i;
  logic        exc_valid_i;
  logic        eret_i;
  logic [31:0] epc_i;
  logic [4:0]  stall_o;
  logic [4:0]  flush_o;
  logic        pc_flush_o;
  logic [31:0] flush_pc_o;
  logic        redirect_pending_o;
  logic [31:0] stall_cycles_o;
  logic [15:0] flush_count_o;

  // Pipeline side: drives requests/events, consumes controls.
  modport master (
    output icache_stall_i, id_stallreq_i, ex_stallreq_i, dcache_stall_i,
           exc_valid_i, eret_i, epc_i,
    input  stall_o, flush_o, pc_flush_o, flush_pc_o, redirect_pending_o,
           stall_cycles_o, flush_count_o
  );

  // Controller side.
  modport slave (
    input  icache_stall_i, id_stallreq_i, ex_stallreq_i, dcache_stall_i,
           exc_valid_i, eret_i, epc_i,
    output stall_o, flush_o, pc_flush_o, flush_pc_o, redirect_pending_o,
           stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: resolves stall requests into per-stage
// hold/bubble controls and redirects fetch on exception/ERET commit. When the
// icache is busy at redirect time the target is parked in HOLD until fetch
// can accept it.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input logic        clk,
  input logic        rst_n,
  pipe_ctrl_if.slave bus
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      r_state;
  logic [31:0] r_hold_pc;
  logic [31:0] r_stall_cyc;
  logic [15:0] r_flush_cnt;

  logic        w_ev;
  logic [31:0] w_target;
  logic [4:0]  w_stall;
  logic [4:0]  w_flush;
  logic        w_pcf;
  logic [31:0] w_fpc;

  // Exception takes priority over ERET when both commit together.
  assign w_ev     = bus.exc_valid_i | bus.eret_i;
  assign w_target = bus.exc_valid_i ? EXC_VECTOR : bus.epc_i;

  // Stall/flush/redirect decode; everything forced quiet while in reset.
  always_comb begin
    w_stall = 5'b0;
    w_flush = 5'b0;
    w_pcf   = 1'b0;
    w_fpc   = 32'h0;
    if (!rst_n) begin
      w_stall = 5'b0;
    end else if (w_ev) begin
      // Redirect kills IF..MEM; only the fetch stage may still be held.
      w_pcf      = 1'b1;
      w_fpc      = w_target;
      w_flush    = 5'b01111;
      w_stall[0] = bus.icache_stall_i;
    end else if (r_state == HOLD) begin
      // Keep presenting the parked target; IF/ID stay cleared until accepted.
      w_pcf      = 1'b1;
      w_fpc      = r_hold_pc;
      w_flush    = 5'b00011;
      w_stall[0] = bus.icache_stall_i;
      if (bus.dcache_stall_i)     w_stall[3:1] = 3'b111;
      else if (bus.ex_stallreq_i) w_stall[3:1] = 3'b011;
      else if (bus.id_stallreq_i) w_stall[3:1] = 3'b001;
    end else begin
      // Highest requesting stage freezes itself and everything upstream,
      // and sends a bubble into the stage just below it.
      if (bus.dcache_stall_i) begin
        w_stall = 5'b01111; w_flush = 5'b10000;
      end else if (bus.ex_stallreq_i) begin
        w_stall = 5'b00111; w_flush = 5'b01000;
      end else if (bus.id_stallreq_i) begin
        w_stall = 5'b00011; w_flush = 5'b00100;
      end else if (bus.icache_stall_i) begin
        w_stall = 5'b00001; w_flush = 5'b00010;
      end
    end
  end

  // Redirect state: park target while icache is busy, newest event wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_hold_pc <= 32'h0;
    end else if (w_ev) begin
      r_hold_pc <= w_target;
      r_state   <= bus.icache_stall_i ? HOLD : IDLE;
    end else if (r_state == HOLD && !bus.icache_stall_i) begin
      r_state   <= IDLE;
    end
  end

  // Statistics: stall cycles wrap, redirect count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cyc <= 32'h0;
      r_flush_cnt <= 16'h0;
    end else begin
      if (|w_stall) r_stall_cyc <= r_stall_cyc + 32'd1;
      if (w_ev && r_flush_cnt != 16'hFFFF) r_flush_cnt <= r_flush_cnt + 16'd1;
    end
  end

  assign bus.stall_o            = w_stall;
  assign bus.flush_o            = w_flush;
  assign bus.pc_flush_o         = w_pcf;
  assign bus.flush_pc_o         = w_fpc;
  assign bus.redirect_pending_o = (r_state == HOLD);
  assign bus.stall_cycles_o     = r_stall_cyc;
  assign bus.flush_count_o      = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: each vector drives inputs just after a rising
// edge and queues its hand-computed expectation; a monitor pops and compares
// on the following falling edge.
module tb_pipe_ctrl;

  logic clk;
  logic rst_n;
  pipe_ctrl_if bus ();

  pipe_ctrl #(.EXC_VECTOR(32'hBFC00380)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  st;
    logic [4:0]  fl;
    logic        pf;
    logic [31:0] fpc;
    logic        pend;
    logic [31:0] scyc;
    logic [15:0] fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, req);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall_o",            e.id, {27'b0, bus.stall_o},          {27'b0, e.st});
      chk("flush_o",            e.id, {27'b0, bus.flush_o},          {27'b0, e.fl});
      chk("pc_flush_o",         e.id, {31'b0, bus.pc_flush_o},       {31'b0, e.pf});
      chk("flush_pc_o",         e.id, bus.flush_pc_o,                e.fpc);
      chk("redirect_pending_o", e.id, {31'b0, bus.redirect_pending_o}, {31'b0, e.pend});
      chk("stall_cycles_o",     e.id, bus.stall_cycles_o,            e.scyc);
      chk("flush_count_o",      e.id, {16'b0, bus.flush_count_o},    {16'b0, e.fcnt});
    end
  end

  // One cycle of stimulus plus its expected response.
  task automatic vec(input logic rst, input logic ic, input logic id,
                     input logic ex, input logic dc, input logic exc,
                     input logic er, input logic [31:0] epc,
                     input logic [4:0] st, input logic [4:0] fl,
                     input logic pf, input logic [31:0] fpc, input logic pend,
                     input logic [31:0] scyc, input logic [15:0] fcnt);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n              = rst;
    bus.icache_stall_i = ic;
    bus.id_stallreq_i  = id;
    bus.ex_stallreq_i  = ex;
    bus.dcache_stall_i = dc;
    bus.exc_valid_i    = exc;
    bus.eret_i         = er;
    bus.epc_i          = epc;
    e.id = vec_id; e.st = st; e.fl = fl; e.pf = pf; e.fpc = fpc;
    e.pend = pend; e.scyc = scyc; e.fcnt = fcnt;
    exp_q.push_back(e);
    vec_id++;
  endtask

  localparam logic [31:0] EV = 32'hBFC00380;
  localparam logic [31:0] EP = 32'h80001234;
  localparam logic [31:0] E2 = 32'h12345678;

  initial begin
    rst_n = 1'b0;
    bus.icache_stall_i = 1'b0; bus.id_stallreq_i = 1'b0;
    bus.ex_stallreq_i  = 1'b0; bus.dcache_stall_i = 1'b0;
    bus.exc_valid_i    = 1'b0; bus.eret_i = 1'b0; bus.epc_i = 32'h0;

    //  rst ic id ex dc exc er epc   stall     flush     pf fpc  pnd scyc fcnt
    vec(0, 1, 0, 1, 0, 1, 0, EP, 5'b00000, 5'b00000, 0, 0,  0, 0,  0); // reset quiet
    vec(1, 0, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00000, 0, 0,  0, 0,  0); // idle
    vec(1, 0, 0, 1, 0, 0, 0, 0,  5'b00111, 5'b01000, 0, 0,  0, 0,  0); // EX stall
    vec(1, 0, 0, 1, 0, 0, 0, 0,  5'b00111, 5'b01000, 0, 0,  0, 1,  0);
    vec(1, 1, 0, 0, 0, 0, 0, 0,  5'b00001, 5'b00010, 0, 0,  0, 2,  0); // IF stall
    vec(1, 0, 1, 0, 0, 0, 0, 0,  5'b00011, 5'b00100, 0, 0,  0, 3,  0); // ID stall
    vec(1, 0, 1, 0, 1, 0, 0, 0,  5'b01111, 5'b10000, 0, 0,  0, 4,  0); // MEM wins
    vec(1, 0, 0, 0, 0, 1, 0, 0,  5'b00000, 5'b01111, 1, EV, 0, 5,  0); // exc, no hold
    vec(1, 0, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00000, 0, 0,  0, 5,  1);
    vec(1, 1, 0, 0, 0, 0, 1, EP, 5'b00001, 5'b01111, 1, EP, 0, 5,  1); // eret, icache busy
    vec(1, 1, 0, 0, 0, 0, 0, 0,  5'b00001, 5'b00011, 1, EP, 1, 6,  2); // HOLD
    vec(1, 1, 0, 0, 0, 0, 0, 0,  5'b00001, 5'b00011, 1, EP, 1, 7,  2);
    vec(1, 0, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00011, 1, EP, 1, 8,  2); // HOLD exit
    vec(1, 0, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00000, 0, 0,  0, 8,  2);
    vec(1, 1, 0, 0, 0, 0, 1, EP, 5'b00001, 5'b01111, 1, EP, 0, 8,  2); // enter HOLD
    vec(1, 1, 0, 0, 0, 1, 0, 0,  5'b00001, 5'b01111, 1, EV, 1, 9,  3); // exc in HOLD
    vec(1, 1, 0, 1, 0, 0, 0, 0,  5'b00111, 5'b00011, 1, EV, 1, 10, 4); // held new target
    vec(1, 0, 0, 0, 1, 0, 0, 0,  5'b01110, 5'b00011, 1, EV, 1, 11, 4); // exit, MEM stall
    vec(1, 0, 0, 0, 1, 1, 1, EP, 5'b00000, 5'b01111, 1, EV, 0, 12, 4); // exc beats eret
    vec(1, 1, 0, 0, 0, 0, 1, E2, 5'b00001, 5'b01111, 1, E2, 0, 12, 5); // enter HOLD
    vec(1, 1, 0, 0, 0, 0, 0, 0,  5'b00001, 5'b00011, 1, E2, 1, 13, 6);
    vec(0, 1, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00000, 0, 0,  0, 0,  0); // reset mid-HOLD
    vec(1, 0, 0, 0, 0, 0, 0, 0,  5'b00000, 5'b00000, 0, 0,  0, 0,  0); // target discarded
    vec(1, 1, 0, 0, 0, 0, 0, 0,  5'b00001, 5'b00010, 0, 0,  0, 0,  0);

    // Drain: every queued expectation must be consumed within a few cycles.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
